// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: shared state encodings, BCD digit limits and display field layout
//   Optional feature macro used by this design: STOP_WATCH_DEBOUNCE_EN
package stop_watch_pkg;
  localparam int DIG_W   = 4;
  localparam logic [DIG_W-1:0] ONES_MAX = 4'd9;
  localparam logic [DIG_W-1:0] TENS_MAX = 4'd5;
  localparam int OFS_CS_O  = 0;
  localparam int OFS_CS_T  = 4;
  localparam int OFS_SEC_O = 8;
  localparam int OFS_SEC_T = 12;
  localparam int OFS_MIN_O = 16;
  localparam int OFS_MIN_T = 20;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } sw_state_t;
  // Field order matches disp_bcd: {min_t,min_o,sec_t,sec_o,cs_t,cs_o}
  typedef struct packed {
    logic [DIG_W-1:0] min_t;
    logic [DIG_W-1:0] min_o;
    logic [DIG_W-1:0] sec_t;
    logic [DIG_W-1:0] sec_o;
    logic [DIG_W-1:0] cs_t;
    logic [DIG_W-1:0] cs_o;
  } bcd_time_t;
endpackage

// File: rtl/stop_watch_btn_cond.sv
// stop_watch_btn_cond: button synchroniser, optional debounce, rising-edge press pulse
//   Ports: clk, rst (async active-low), ms_tick (1 ms strobe), btn (async level),
//          press (one-clk pulse per accepted press)
//   Macro STOP_WATCH_DEBOUNCE_EN enables the DEB_MS-tick stability filter.
module stop_watch_btn_cond #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic btn,
  output logic press
);
  logic [1:0] sync;
  logic       lvl;
  logic       lvl_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= '0;
    else      sync <= {sync[0], btn};
`ifdef STOP_WATCH_DEBOUNCE_EN
  logic [4:0] cnt;
  // Count ms ticks while the synchronised input disagrees with the accepted
  // level; any agreement restarts the window.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == lvl) begin
      cnt <= '0;
    end else if (ms_tick) begin
      if (cnt == 5'(DEB_MS - 1)) begin
        lvl <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 5'd1;
      end
    end
`else
  logic unused_deb;
  assign lvl        = sync[1];
  assign unused_deb = ms_tick ^ (^5'(DEB_MS));
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lvl_q <= 1'b0;
      press <= 1'b0;
    end else begin
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
    end
endmodule

// File: rtl/stop_watch_run_ctl.sv
// stop_watch_run_ctl: stopwatch run/pause/lap FSM with BCD mm:ss.cc count and lap hold
//   Ports: clk, rst (async active-low), pls_1khz / pls_100hz (square waves),
//          btn_start / btn_lap (async buttons), disp_bcd (registered display digits),
//          state, running, lap_active, overflow (sticky wrap flag)
//   Macro STOP_WATCH_DEBOUNCE_EN enables button debouncing (DEB_MS ms window).
module stop_watch_run_ctl
  import stop_watch_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter int DEB_MS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pls_1khz,
  input  logic        pls_100hz,
  input  logic        btn_start,
  input  logic        btn_lap,
  output logic [23:0] disp_bcd,
  output logic [1:0]  state,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);
  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);
  sw_state_t state_q, state_n;
  bcd_time_t cnt_q, cnt_inc, lap_q;
  logic [23:0] disp_q;
  logic p100_q, p1k_q, cs_tick, ms_tick;
  logic start_press, lap_press;
  logic capture, clear, wrap, counting;
  logic c_cs, c_sec_o, c_sec, min_last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p100_q  <= 1'b0;
      p1k_q   <= 1'b0;
      cs_tick <= 1'b0;
      ms_tick <= 1'b0;
    end else begin
      p100_q  <= pls_100hz;
      p1k_q   <= pls_1khz;
      cs_tick <= pls_100hz & ~p100_q;
      ms_tick <= pls_1khz & ~p1k_q;
    end
  stop_watch_btn_cond #(.DEB_MS(DEB_MS)) u_start (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .btn(btn_start), .press(start_press)
  );
  stop_watch_btn_cond #(.DEB_MS(DEB_MS)) u_lap (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .btn(btn_lap), .press(lap_press)
  );
  // Start is checked first in every state, so a coincident lap pulse is dropped.
  always_comb begin
    state_n = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE:  state_n = start_press ? S_RUN : S_IDLE;
      S_RUN: begin
        state_n = start_press ? S_PAUSE : lap_press ? S_LAP : S_RUN;
        capture = ~start_press & lap_press;
      end
      S_LAP:   state_n = start_press ? S_PAUSE : lap_press ? S_RUN : S_LAP;
      S_PAUSE: begin
        state_n = start_press ? S_RUN : lap_press ? S_IDLE : S_PAUSE;
        clear   = ~start_press & lap_press;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  always_comb begin
    c_cs     = (cnt_q.cs_o == ONES_MAX) & (cnt_q.cs_t == ONES_MAX);
    c_sec_o  = c_cs & (cnt_q.sec_o == ONES_MAX);
    c_sec    = c_sec_o & (cnt_q.sec_t == TENS_MAX);
    min_last = (cnt_q.min_t == MAX_T) & (cnt_q.min_o == MAX_O);
    wrap     = c_sec & min_last;
    cnt_inc.cs_o  = (cnt_q.cs_o == ONES_MAX) ? 4'd0 : cnt_q.cs_o + 4'd1;
    cnt_inc.cs_t  = (cnt_q.cs_o != ONES_MAX) ? cnt_q.cs_t :
                    (cnt_q.cs_t == ONES_MAX) ? 4'd0 : cnt_q.cs_t + 4'd1;
    cnt_inc.sec_o = !c_cs ? cnt_q.sec_o :
                    (cnt_q.sec_o == ONES_MAX) ? 4'd0 : cnt_q.sec_o + 4'd1;
    cnt_inc.sec_t = !c_sec_o ? cnt_q.sec_t :
                    (cnt_q.sec_t == TENS_MAX) ? 4'd0 : cnt_q.sec_t + 4'd1;
    cnt_inc.min_o = !c_sec ? cnt_q.min_o :
                    (min_last || cnt_q.min_o == ONES_MAX) ? 4'd0 : cnt_q.min_o + 4'd1;
    cnt_inc.min_t = !c_sec ? cnt_q.min_t :
                    min_last ? 4'd0 :
                    (cnt_q.min_o == ONES_MAX) ? cnt_q.min_t + 4'd1 : cnt_q.min_t;
  end
  assign counting = cs_tick & (state_q == S_RUN || state_q == S_LAP);
  // Lap capture takes the pre-increment count even when a tick lands on the same edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q    <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
      disp_q   <= '0;
    end else begin
      cnt_q    <= clear ? '0 : counting ? cnt_inc : cnt_q;
      lap_q    <= clear ? '0 : capture ? cnt_q : lap_q;
      overflow <= clear ? 1'b0 : (counting & wrap) | overflow;
      disp_q   <= (state_q == S_LAP) ? lap_q : cnt_q;
    end
  assign disp_bcd   = disp_q;
  assign state      = state_q;
  assign running    = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);
endmodule

// File: tb/tb_stop_watch_run_ctl.sv
// tb_stop_watch_run_ctl: directed self-checking bench for stop_watch_run_ctl
module tb_stop_watch_run_ctl;
`ifdef STOP_WATCH_DEBOUNCE_EN
  localparam int HOLD = 60;
`else
  localparam int HOLD = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pls_1khz = 1'b0;
  logic pls_100hz = 1'b0;
  logic btn_start = 1'b0;
  logic btn_lap = 1'b0;
  logic [23:0] disp_bcd;
  logic [1:0] state;
  logic running, lap_active, overflow;
  int n_vec = 0;
  int n_err = 0;
  stop_watch_run_ctl #(.MAX_MIN(1), .DEB_MS(20)) u_dut (
    .clk(clk), .rst(rst), .pls_1khz(pls_1khz), .pls_100hz(pls_100hz),
    .btn_start(btn_start), .btn_lap(btn_lap), .disp_bcd(disp_bcd),
    .state(state), .running(running), .lap_active(lap_active), .overflow(overflow)
  );
  always #4 clk = ~clk;
  initial forever begin
    @(negedge clk);
    pls_1khz = ~pls_1khz;
  end
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pls_100hz = 1'b1;
      @(negedge clk);
      pls_100hz = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    repeat (HOLD) @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 24'(state), 24'd0);
    chk("rst_disp", disp_bcd, 24'h0);
    chk("rst_ovf", 24'(overflow), 24'd0);
    chk("rst_run", 24'(running), 24'd0);
    chk("rst_lap", 24'(lap_active), 24'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1);
    chk("idle_lap_ign", 24'(state), 24'd0);
    press(1'b1, 1'b0);
    chk("start_state", 24'(state), 24'd1);
    ticks(250);
    chk("run_250", disp_bcd, 24'h000250);
    chk("run_running", 24'(running), 24'd1);
    chk("run_lapact", 24'(lap_active), 24'd0);
    ticks(97);
    chk("run_347", disp_bcd, 24'h000347);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 24'(state), 24'd0);
    chk("mid_rst_disp", disp_bcd, 24'h0);
    chk("mid_rst_ovf", 24'(overflow), 24'd0);
    @(negedge clk);
    rst = 1'b1;
    ticks(5);
    chk("idle_no_cnt", disp_bcd, 24'h0);
    press(1'b1, 1'b0);
    ticks(120);
    chk("run_120", disp_bcd, 24'h000120);
    press(1'b0, 1'b1);
    chk("lap_state", 24'(state), 24'd3);
    chk("lap_active", 24'(lap_active), 24'd1);
    chk("lap_running", 24'(running), 24'd1);
    ticks(30);
    chk("lap_frozen", disp_bcd, 24'h000120);
    press(1'b0, 1'b1);
    chk("unlap_state", 24'(state), 24'd1);
    chk("unlap_disp", disp_bcd, 24'h000150);
    ticks(10);
    press(1'b1, 1'b1);
    chk("both_state", 24'(state), 24'd2);
    chk("both_lapreg", u_dut.lap_q, 24'h000120);
    chk("pause_disp", disp_bcd, 24'h000160);
    chk("pause_running", 24'(running), 24'd0);
    ticks(4);
    chk("pause_hold", disp_bcd, 24'h000160);
    press(1'b0, 1'b1);
    chk("clr_state", 24'(state), 24'd0);
    chk("clr_disp", disp_bcd, 24'h0);
    chk("clr_lapreg", u_dut.lap_q, 24'h0);
    press(1'b1, 1'b0);
    ticks(11999);
    chk("max_disp", disp_bcd, 24'h015999);
    chk("max_ovf", 24'(overflow), 24'd0);
    ticks(1);
    chk("wrap_disp", disp_bcd, 24'h0);
    chk("wrap_ovf", 24'(overflow), 24'd1);
    ticks(5);
    chk("wrap_cont", disp_bcd, 24'h000005);
    chk("wrap_state", 24'(state), 24'd1);
    press(1'b1, 1'b0);
    chk("ovf_pause_keep", 24'(overflow), 24'd1);
    press(1'b0, 1'b1);
    chk("ovf_clr", 24'(overflow), 24'd0);
    chk("ovf_clr_state", 24'(state), 24'd0);
`ifdef STOP_WATCH_DEBOUNCE_EN
    begin
      int n_p;
      int first;
      n_p = 0;
      first = -1;
      for (int i = 0; i < 3; i++) begin
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        if (u_dut.start_press) n_p++;
        btn_start = 1'b0;
        repeat (2) @(negedge clk);
        if (u_dut.start_press) n_p++;
      end
      btn_start = 1'b1;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (u_dut.start_press) begin
          n_p++;
          if (first < 0) first = i;
        end
      end
      chk("deb_one_press", 24'(n_p), 24'd1);
      chk("deb_latency", 24'(first >= 38 && first <= 48), 24'd1);
      chk("deb_state", 24'(state), 24'd1);
      btn_start = 1'b0;
      repeat (60) @(negedge clk);
      n_p = 0;
      btn_lap = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (u_dut.lap_press) n_p++;
      end
      btn_lap = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (u_dut.lap_press) n_p++;
      end
      chk("glitch_no_press", 24'(n_p), 24'd0);
      chk("glitch_state", 24'(state), 24'd1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stop_watch_run_ctl.md
Name: stop_watch_run_ctl

Overview:
Run/stop/lap controller for the stopwatch. Consumes the 1 kHz and 100 Hz square-wave outputs of the pulse generator and two push-buttons. Sequences a 4-state FSM and keeps a BCD mm:ss.cc time count plus a lap-hold register. Drives the display digits and status flags toward the 7-segment scanner.

Parameters:
MAX_MIN, 59, last minute value before wrap (0..99); count wraps after MAX_MIN:59.99
DEB_MS, 20, debounce stability window in 1 kHz ticks (1..31); used only with the debounce feature

Ports:
clk  input  1  125 MHz system clock
rst  input  1  asynchronous active-low reset
pls_1khz  input  1  1 kHz square wave, synchronous to clk
pls_100hz  input  1  100 Hz square wave, synchronous to clk
btn_start  input  1  start/stop button, active-high, asynchronous level
btn_lap  input  1  lap/clear button, active-high, asynchronous level
disp_bcd  output  24  {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, 4-bit BCD each
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky flag, set on wrap

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; live count, lap register and disp_bcd=0; running=0, lap_active=0, overflow=0; all sync/debounce/edge registers cleared.
- Tick detect: cs_tick is the registered rising edge of pls_100hz, one clk wide. pls_1khz rising edge is detected the same way (ms_tick).
- Button path: 2-FF synchroniser, optional debounce, then rising-edge detect giving a 1-cycle press pulse.
  - Without debounce: press pulse on the 3rd clk edge after the button goes high.
- FSM (evaluated on press pulses):
  - IDLE: start goes to RUN; lap is ignored.
  - RUN: start goes to PAUSE; lap goes to LAP and lap_reg captures the live count.
  - LAP: lap goes to RUN (display unfreezes); start goes to PAUSE (display shows live count).
  - PAUSE: start goes to RUN; lap goes to IDLE, clearing the live count, lap_reg and overflow.
  - Start and lap pulses in the same cycle: start wins, lap is discarded.
- Counting: the live count increments on cs_tick only in RUN or LAP.
  - BCD ripple: cs_o 9 to 0 carries to cs_t; cs_t 9 to 0 carries to sec_o; sec 59 to 00 carries to minutes.
  - Minutes are BCD 00..MAX_MIN.
  - At MAX_MIN:59.99 the next tick gives 00:00.00 and sets overflow; counting continues.
- Lap capture on the same edge as cs_tick: lap_reg takes the pre-increment value; the live count still increments.
- disp_bcd is registered. It shows lap_reg in LAP, otherwise the live count, and updates 1 clk after the live count changes.
- running and lap_active are decoded from the registered state (no extra latency).
- Illegal digit values cannot occur. Any unreachable state encoding recovers to IDLE.

Optional Feature:
STOP_WATCH_DEBOUNCE_EN
- Defined: a synchronised button level is accepted only after it holds the same value for DEB_MS consecutive ms_tick events. A 5-bit counter per button restarts on any mismatch. The press pulse comes 1 clk after the accepted level rises.
- Undefined: no debounce; synchroniser plus edge detect only; DEB_MS and pls_1khz are unused.

Decomposition:
- Package stop_watch_pkg: state encodings (IDLE/RUN/PAUSE/LAP), BCD digit width 4, digit limits (9, 5), disp_bcd field offsets.
- Sub-module stop_watch_btn_cond: synchroniser, optional debounce and edge detect for one button. Instantiated twice.
- FSM, BCD counter and display mux stay in the top level.

Test Plan:
- Reset mid-RUN at 00:03.47 -> same cycle: state=0, disp_bcd=0, overflow=0; counting resumes only after a new start press.
- IDLE, start press, 250 cs_ticks -> state=1, disp_bcd=00:02.50, running=1.
- RUN at 00:01.20, lap press, 30 ticks -> state=3, disp shows 00:01.20, live count 00:01.50; lap press -> disp 00:01.50.
- MAX_MIN=1, run to 01:59.99, 1 tick -> disp 00:00.00, overflow=1; pause then lap -> IDLE, overflow=0.
- Start and lap pulses in the same cycle while RUN -> state=PAUSE, lap_reg unchanged.
- STOP_WATCH_DEBOUNCE_EN, DEB_MS=20:
  - Button bounce of 5 ms then stable high -> exactly one press pulse, 20 ms after the last bounce.
  - 10 ms glitch -> no press.
